// File: rtl/vram_pkg.sv
// vram_pkg: shared defaults, clear-engine state type and parity helper for vram_multiport.
//   DATA_W_DEF/ADDR_W_DEF/DEPTH_DEF/NUM_RD_DEF : default geometry
//   clrState_t : clear sweep states (IDLE, SWEEP)
//   evenParity : even parity of a word, zero-extended to 32 bits
package vram_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 13;
   localparam int DEPTH_DEF  = 5120;
   localparam int NUM_RD_DEF = 2;
   typedef enum logic {IDLE, SWEEP} clrState_t;
   // Zero extension leaves parity unchanged, so any DATA_W up to 32 fits.
   function automatic logic evenParity(input logic [31:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/vram_bank.sv
// vram_bank: one 1W1R inferred block RAM with registered read and no array reset.
//   clk            : clock
//   wrEn/wrAddr/wrData : write port, write lands at the clock edge
//   rdEn/rdAddr    : read request, rdData updates one cycle later and holds otherwise
//   rdData         : registered read data (read-first with respect to a same-address write)
module vram_bank #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 13,
   parameter int DEPTH  = 5120
) (
   input  logic              clk,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [WIDTH-1:0]  wrData,
   input  logic              rdEn,
   input  logic [ADDR_W-1:0] rdAddr,
   output logic [WIDTH-1:0]  rdData
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (wrEn) mem[wrAddr] <= wrData;
      if (rdEn) rdData <= mem[rdAddr];
   end
endmodule

// File: rtl/vram_multiport.sv
// vram_multiport: NUM_RD mirrored 1W1R VRAM banks with read-during-write forwarding
// and a hardware clear engine.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   wr_addr/wr_data/wr_en       : host write, accepted when wr_en && wr_ready
//   wr_ready                    : low in reset and during a clear sweep
//   rd_addr/rd_en               : per-port read request (flat, port i at [i*ADDR_W +: ADDR_W])
//   rd_data/rd_valid            : per-port data one cycle after rd_en, held between reads
//   clr_start/clr_value         : start a sweep filling every word with clr_value
//   clr_busy                    : sweep in progress
// Optional build macro VRAM_PARITY_EN adds a stored even-parity bit per word,
//   output rd_perr (per port, aligned with rd_valid) and input inj_perr
//   (inverts the stored parity bit of an accepted host write).
module vram_multiport
   import vram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int NUM_RD = NUM_RD_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_en,
   output logic                     wr_ready,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   input  logic [NUM_RD-1:0]        rd_en,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_valid,
   input  logic                     clr_start,
   input  logic [DATA_W-1:0]        clr_value,
`ifdef VRAM_PARITY_EN
   output logic [NUM_RD-1:0]        rd_perr,
   input  logic                     inj_perr,
`endif
   output logic                     clr_busy
);
`ifdef VRAM_PARITY_EN
   localparam int BW = DATA_W + 1;
`else
   localparam int BW = DATA_W;
`endif
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   clrState_t         state, stateNext;
   logic [ADDR_W-1:0] clrAddr, clrAddrNext;
   logic [DATA_W-1:0] clrVal;
   logic              readyQ;
   logic              hostWr;
   logic              bankWe;
   logic [ADDR_W-1:0] bankAddr;
   logic [DATA_W-1:0] bankData;
   logic [BW-1:0]     bankWord;
   logic              wrFlagQ;
   logic [ADDR_W-1:0] wrAddrQ;
   logic [BW-1:0]     wrWordQ;

   assign clr_busy = state == SWEEP;
   assign wr_ready = readyQ && !clr_busy;
   assign hostWr   = wr_en && wr_ready;

   // Clear FSM: state and sweep counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         clrAddr <= '0;
      end else begin
         state   <= stateNext;
         clrAddr <= clrAddrNext;
      end
   end

   always_comb begin
      stateNext   = state;
      clrAddrNext = clrAddr;
      if (state == IDLE && clr_start) begin
         stateNext   = SWEEP;
         clrAddrNext = '0;
      end else if (state == SWEEP) begin
         clrAddrNext = clrAddr + 1'b1;
         if (clrAddr == LAST_ADDR) stateNext = IDLE;
      end
   end

   // wr_ready rises on the first clock after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         readyQ <= 1'b0;
         clrVal <= '0;
      end else begin
         readyQ <= 1'b1;
         if (state == IDLE && clr_start) clrVal <= clr_value;
      end
   end

   // Sweep owns the write port; out-of-range host writes are accepted but never reach a bank
   assign bankWe   = clr_busy || (hostWr && {1'b0, wr_addr} < DEPTH_C);
   assign bankAddr = clr_busy ? clrAddr : wr_addr;
   assign bankData = clr_busy ? clrVal : wr_data;
`ifdef VRAM_PARITY_EN
   assign bankWord = {evenParity(32'(bankData)) ^ (!clr_busy && inj_perr), bankData};
`else
   assign bankWord = bankData;
`endif

   // Last cycle's bank write, used to replace the banks' read-first data on a collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrFlagQ <= 1'b0;
         wrAddrQ <= '0;
         wrWordQ <= '0;
      end else begin
         wrFlagQ <= bankWe;
         wrAddrQ <= bankAddr;
         wrWordQ <= bankWord;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_port
      logic [ADDR_W-1:0] rAddr;
      logic              inRange;
      logic [BW-1:0]     bankQ;
      logic [BW-1:0]     wordNow;
      logic [ADDR_W-1:0] rAddrQ;
      logic              inRangeQ;
      logic              validQ;
      logic [DATA_W-1:0] holdQ;

      assign rAddr   = rd_addr[i*ADDR_W +: ADDR_W];
      assign inRange = {1'b0, rAddr} < DEPTH_C;

      vram_bank #(.WIDTH(BW), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bank (
         .clk    (clk),
         .wrEn   (bankWe),
         .wrAddr (bankAddr),
         .wrData (bankWord),
         .rdEn   (rd_en[i] && inRange),
         .rdAddr (rAddr),
         .rdData (bankQ)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            validQ   <= 1'b0;
            inRangeQ <= 1'b0;
            rAddrQ   <= '0;
            holdQ    <= '0;
         end else begin
            validQ <= rd_en[i];
            if (rd_en[i]) begin
               inRangeQ <= inRange;
               rAddrQ   <= rAddr;
            end
            if (validQ) holdQ <= rd_data[i*DATA_W +: DATA_W];
         end
      end

      assign wordNow = !inRangeQ ? '0 :
                       (wrFlagQ && wrAddrQ == rAddrQ) ? wrWordQ : bankQ;
      // Between reads the port shows the last delivered word, not the live mux
      assign rd_data[i*DATA_W +: DATA_W] = validQ ? wordNow[DATA_W-1:0] : holdQ;
      assign rd_valid[i] = validQ;
`ifdef VRAM_PARITY_EN
      assign rd_perr[i] = validQ && (wordNow[DATA_W] != evenParity(32'(wordNow[DATA_W-1:0])));
`endif
   end
endmodule

// File: tb/tb_vram_multiport.sv
// tb_vram_multiport: randomized and directed checks of vram_multiport against an array model.
module tb_vram_multiport;
   localparam int DW = 8, AW = 13, DEPTH = 5120, NRD = 2;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic wr_en = 1'b0, wr_ready;
   logic [NRD*AW-1:0] rd_addr = '0;
   logic [NRD-1:0] rd_en = '0, rd_valid;
   logic [NRD*DW-1:0] rd_data;
   logic clr_start = 1'b0, clr_busy;
   logic [DW-1:0] clr_value = '0;

   int total = 0, bad = 0;

   always #5 clk = ~clk;

   vram_multiport #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_RD(NRD)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_ready(wr_ready),
      .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy)
   );

   // Model: memory contents, what the next outputs must be, and clear progress
   int mem[DEPTH];
   bit known[DEPTH];
   bit mReady = 0, mSweep = 0, lastAcc = 0;
   int mIdx = 0, mClrVal = 0, busyCycles = 0;
   int expData[NRD];
   bit expKnown[NRD], expValid[NRD];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic setRd(input int p, input int a);
      rd_addr[p*AW +: AW] = AW'(a);
      rd_en[p] = 1'b1;
   endtask

   task automatic setWr(input int a, input int d);
      wr_addr = AW'(a);
      wr_data = DW'(d);
      wr_en = 1'b1;
   endtask

   task automatic idleIn();
      wr_en = 1'b0;
      rd_en = '0;
      clr_start = 1'b0;
   endtask

   // One clock: predict from the inputs now applied, then compare just after the edge
   task automatic cycle();
      int a;
      if (!rst_n) begin
         mReady = 0;
         mSweep = 0;
         lastAcc = 0;
         for (int p = 0; p < NRD; p++) begin
            expValid[p] = 0;
            expData[p] = 0;
            expKnown[p] = 1;
         end
      end else begin
         lastAcc = wr_en && mReady && !mSweep;
         if (mSweep) begin
            mem[mIdx] = mClrVal;
            known[mIdx] = 1;
         end else if (lastAcc && int'(wr_addr) < DEPTH) begin
            mem[wr_addr] = int'(wr_data);
            known[wr_addr] = 1;
         end
         for (int p = 0; p < NRD; p++) begin
            expValid[p] = rd_en[p];
            if (rd_en[p]) begin
               a = int'(rd_addr[p*AW +: AW]);
               expData[p] = a < DEPTH ? mem[a] : 0;
               expKnown[p] = a < DEPTH ? known[a] : 1'b1;
            end
         end
         if (mSweep) begin
            mIdx++;
            if (mIdx == DEPTH) mSweep = 0;
         end else if (clr_start) begin
            mSweep = 1;
            mIdx = 0;
            mClrVal = int'(clr_value);
         end
         mReady = 1;
      end
      @(posedge clk);
      #1;
      if (clr_busy === 1'b1) busyCycles++;
      check("wr_ready", 32'(wr_ready), 32'(mReady && !mSweep));
      check("clr_busy", 32'(clr_busy), 32'(mSweep));
      for (int p = 0; p < NRD; p++) begin
         check($sformatf("rd_valid%0d", p), 32'(rd_valid[p]), 32'(expValid[p]));
         if (expKnown[p]) check($sformatf("rd_data%0d", p), 32'(rd_data[p*DW +: DW]), 32'(expData[p]));
      end
   endtask

   task automatic randCycle();
      int a;
      idleIn();
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, 2**AW - 1)) : int'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) setWr(a, int'($urandom_range(0, 255)));
      for (int p = 0; p < NRD; p++)
         if ($urandom_range(0, 2) != 0) begin
            case ($urandom_range(0, 3))
               0: setRd(p, a);
               1: setRd(p, int'($urandom_range(DEPTH, 2**AW - 1)));
               default: setRd(p, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, DEPTH - 1)));
            endcase
         end
      cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held for three cycles
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) cycle();
      check("rst_wr_ready", 32'(wr_ready), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      rst_n = 1'b1;
      cycle();
      check("ready_after_release", 32'(wr_ready), 1);

      // Mirroring
      setWr('h100, 'h5A);
      cycle();
      idleIn();
      setRd(0, 'h100);
      setRd(1, 'h100);
      cycle();
      idleIn();
      check("mirror_p0", 32'(rd_data[7:0]), 'h5A);
      check("mirror_p1", 32'(rd_data[15:8]), 'h5A);
      check("mirror_valid", 32'(rd_valid), 3);
      cycle();
      check("hold_p0", 32'(rd_data[7:0]), 'h5A);

      // Read-during-write forwarding
      setWr('h20, 'h11);
      cycle();
      setWr('h20, 'h22);
      setRd(1, 'h20);
      cycle();
      idleIn();
      check("fwd_p1", 32'(rd_data[15:8]), 'h22);

      // Full clear sweep
      busyCycles = 0;
      clr_value = 8'h20;
      clr_start = 1'b1;
      cycle();
      clr_start = 1'b0;
      for (int k = 0; k < DEPTH + 20 && mSweep; k++) cycle();
      cycle();
      check("busy_len", busyCycles, DEPTH);
      setRd(0, 'h0000);
      setRd(1, 'h13FF);
      cycle();
      idleIn();
      check("clr_0000", 32'(rd_data[7:0]), 'h20);
      check("clr_13FF", 32'(rd_data[15:8]), 'h20);
      setRd(0, 'h0A00);
      setRd(1, 'h1400);
      setWr('h1400, 'hEE);
      cycle();
      idleIn();
      check("clr_0A00", 32'(rd_data[7:0]), 'h20);
      check("oob_data", 32'(rd_data[15:8]), 0);
      check("oob_valid", 32'(rd_valid[1]), 1);

      // Host write held across a sweep
      clr_value = 8'h44;
      clr_start = 1'b1;
      cycle();
      clr_start = 1'b0;
      for (int k = 0; k < 10; k++) cycle();
      setWr('h0005, 'h77);
      lastAcc = 0;
      for (int k = 0; k < DEPTH + 20; k++) begin
         cycle();
         if (lastAcc) break;
      end
      check("held_accepted", 32'(lastAcc), 1);
      idleIn();
      setRd(0, 'h0005);
      cycle();
      idleIn();
      check("held_data", 32'(rd_data[7:0]), 'h77);

      for (int k = 0; k < 3000; k++) randCycle();
      idleIn();

      // Write and clear start together, then abort the sweep with reset
      setWr(3, 'h99);
      clr_value = 8'h33;
      clr_start = 1'b1;
      cycle();
      idleIn();
      for (int k = 0; k < 100; k++) cycle();
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(clr_busy), 0);
      check("abort_ready", 32'(wr_ready), 0);
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      setRd(0, 3);
      setRd(1, 150);
      cycle();
      idleIn();
      check("abort_cleared", 32'(rd_data[7:0]), 'h33);
      check("abort_untouched_valid", 32'(rd_valid[1]), 1);
      for (int k = 0; k < 500; k++) randCycle();
      idleIn();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
